// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller: buffered output FIFO toward the console,
// a latched single-byte input register and a status/sticky-error register.
module io_port_ctrl #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_sel,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid
);

    localparam int IDX_W = $clog2(OUT_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_OUT = BASE_ADDR;
    localparam logic [ADDR_W-1:0] ADDR_IN  = ADDR_W'(BASE_ADDR + 1);
    localparam logic [ADDR_W-1:0] ADDR_ST  = ADDR_W'(BASE_ADDR + 2);

    // ---------------------------------------------------------------
    // Address decode and access qualification
    // ---------------------------------------------------------------
    logic hit_out;
    logic hit_in;
    logic hit_st;
    logic miss;
    logic wr_fire;
    logic rd_fire;

    assign hit_out = (addr == ADDR_OUT);
    assign hit_in  = (addr == ADDR_IN);
    assign hit_st  = (addr == ADDR_ST);
    assign miss    = !(hit_out || hit_in || hit_st);

    // A simultaneous write and read is treated as a write only.
    assign wr_fire  = io_sel && io_wr;
    assign rd_fire  = io_sel && io_rd && !io_wr;
    assign rdata_oe = rd_fire;

    // ---------------------------------------------------------------
    // Output FIFO
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              ovf_set;

    assign wr_idx     = wr_ptr_reg[IDX_W-1:0];
    assign rd_idx     = rd_ptr_reg[IDX_W-1:0];
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) && (wr_idx == rd_idx);

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push_req  = wr_fire && hit_out;
    // A pop in the same cycle frees the slot the push lands in.
    assign push      = push_req && (!fifo_full || pop);
    assign ovf_set   = push_req && fifo_full && !pop;

    // Head is gated while empty so stale RAM contents never reach the console.
    assign out_data = fifo_empty ? '0 : fifo_mem[rd_idx];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // ---------------------------------------------------------------
    // Input holding register
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] in_hold_reg;
    logic [DATA_W-1:0] in_hold_next;
    logic              in_full_reg;
    logic              in_full_next;
    logic              in_rd;
    logic              capture;
    logic              ovr_set;

    assign in_rd = rd_fire && hit_in;
    // A CPU read in the same cycle empties the register, so a new byte fits.
    assign capture = in_valid && (!in_full_reg || in_rd);
    assign ovr_set = in_valid && in_full_reg && !in_rd;

    always_comb begin
        in_hold_next = in_hold_reg;
        in_full_next = in_full_reg;
        if (capture) begin
            in_hold_next = in_data;
            in_full_next = 1'b1;
        end else if (in_rd) begin
            in_full_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_hold_reg <= '0;
            in_full_reg <= 1'b0;
        end else begin
            in_hold_reg <= in_hold_next;
            in_full_reg <= in_full_next;
        end
    end

    // ---------------------------------------------------------------
    // Sticky flags {err, ovr, ovf}, write-1-to-clear on status bits 5:3
    // ---------------------------------------------------------------
    logic       err_set;
    logic       st_wr;
    logic [2:0] flag_set;
    logic [2:0] flag_reg;
    logic [2:0] flag_next;

    assign err_set  = io_sel && (io_wr || io_rd) && miss;
    assign st_wr    = wr_fire && hit_st;
    assign flag_set = {err_set, ovr_set, ovf_set};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            // Setting has priority over a same-cycle clear.
            assign flag_next[gi] = flag_set[gi] |
                                   (flag_reg[gi] & ~(st_wr & wdata[3+gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_reg <= '0;
        end else begin
            flag_reg <= flag_next;
        end
    end

    // ---------------------------------------------------------------
    // Read data mux
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] status_word;

    always_comb begin
        status_word      = '0;
        status_word[5:0] = {flag_reg, in_full_reg, fifo_empty, fifo_full};
    end

    always_comb begin
        rdata = '0;
        if (rd_fire) begin
            if (hit_in) begin
                rdata = in_full_reg ? in_hold_reg : '0;
            end else if (hit_st) begin
                rdata = status_word;
            end
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: expected read data and console
// bytes are queued when stimulus is driven and compared as the DUT produces them.
module tb_io_port_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_sel;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_oe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rd_q[$];
    logic [7:0] out_q[$];

    io_port_ctrl #(
        .DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'h00), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .io_sel(io_sel), .io_wr(io_wr), .io_rd(io_rd),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives at the falling edge; the DUT commits at the next rising edge.
    task automatic wr_io(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        io_sel = 1'b1; io_wr = 1'b1; io_rd = 1'b0; addr = a; wdata = d;
        if (a == 8'h00 && out_q.size() < DEPTH) out_q.push_back(d);
        $display("WR  addr=%02h data=%02h", a, d);
        @(posedge clk); #1;
        io_sel = 1'b0; io_wr = 1'b0;
    endtask

    task automatic rd_io(input logic [7:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        @(negedge clk);
        io_sel = 1'b1; io_rd = 1'b1; io_wr = 1'b0; addr = a;
        rd_q.push_back(exp);
        #2;
        e = rd_q.pop_front();
        $display("RD  addr=%02h data=%02h oe=%0b", a, rdata, rdata_oe);
        check(tag, rdata, e);
        check({tag, "_oe"}, rdata_oe, 1);
        @(posedge clk); #1;
        io_sel = 1'b0; io_rd = 1'b0;
    endtask

    task automatic strobe_in(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        $display("IN  data=%02h", d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        logic [7:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        while (out_q.size() > 0 && guard < 20) begin
            #2;
            if (out_valid) begin
                e = out_q.pop_front();
                $display("OUT data=%02h", out_data);
                check("drain", out_data, e);
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("drain_left", out_q.size(), 0);
        check("empty_after_drain", out_valid, 0);
    endtask

    initial begin
        logic [7:0] e;
        reset = 1'b1; io_sel = 0; io_wr = 0; io_rd = 0; addr = 0; wdata = 0;
        out_ready = 0; in_data = 0; in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rdata_oe", rdata_oe, 0);
        check("rst_rdata", rdata, 0);
        rd_io(8'h02, 8'h02, "rst_status");

        // Fill FIFO, then overflow
        wr_io(8'h00, 8'h11); wr_io(8'h00, 8'h22); wr_io(8'h00, 8'h33); wr_io(8'h00, 8'h44);
        rd_io(8'h02, 8'h01, "full_status");
        wr_io(8'h00, 8'h55);
        rd_io(8'h02, 8'h09, "ovf_status");
        rd_io(8'h00, 8'h00, "out_read_zero");
        wr_io(8'h02, 8'h08);
        rd_io(8'h02, 8'h01, "ovf_cleared");

        // Full FIFO: push AA with a pop in the same cycle
        @(negedge clk);
        io_sel = 1; io_wr = 1; addr = 8'h00; wdata = 8'hAA; out_ready = 1;
        $display("WR  addr=00 data=AA with pop");
        #2;
        e = out_q.pop_front();
        check("pushpop_valid", out_valid, 1);
        check("pushpop_head", out_data, e);
        out_q.push_back(8'hAA);
        @(posedge clk); #1;
        io_sel = 0; io_wr = 0; out_ready = 0;
        rd_io(8'h02, 8'h01, "pushpop_no_ovf");
        drain();
        rd_io(8'h02, 8'h02, "drained_status");

        // Push into empty FIFO: no bypass
        @(negedge clk);
        io_sel = 1; io_wr = 1; addr = 8'h00; wdata = 8'h7E;
        out_q.push_back(8'h7E);
        $display("WR  addr=00 data=7E");
        #2;
        check("nobypass_valid", out_valid, 0);
        @(posedge clk); #1;
        io_sel = 0; io_wr = 0;
        @(negedge clk);
        check("push_valid_next", out_valid, 1);
        check("push_data_next", out_data, 8'h7E);
        drain();

        // Input overrun
        strobe_in(8'h42);
        rd_io(8'h02, 8'h06, "in_full_status");
        strobe_in(8'h43);
        rd_io(8'h02, 8'h16, "ovr_status");
        rd_io(8'h01, 8'h42, "in_read_old");
        rd_io(8'h02, 8'h12, "in_cleared");
        rd_io(8'h01, 8'h00, "in_read_empty");
        wr_io(8'h02, 8'h10);
        rd_io(8'h02, 8'h02, "ovr_cleared");

        // Same-cycle IN read and capture
        strobe_in(8'h5A);
        @(negedge clk);
        io_sel = 1; io_rd = 1; addr = 8'h01; in_valid = 1; in_data = 8'h99;
        rd_q.push_back(8'h5A);
        #2;
        e = rd_q.pop_front();
        $display("RD  addr=01 data=%02h with IN 99", rdata);
        check("rd_capture_old", rdata, e);
        @(posedge clk); #1;
        io_sel = 0; io_rd = 0; in_valid = 0;
        rd_io(8'h02, 8'h06, "rd_capture_no_ovr");
        rd_io(8'h01, 8'h99, "rd_capture_new");

        // Out-of-map access, combined clear
        strobe_in(8'h01);
        strobe_in(8'h02);
        rd_io(8'h05, 8'h00, "unmapped_read");
        rd_io(8'h02, 8'h36, "err_ovr_status");
        wr_io(8'h02, 8'h38);
        rd_io(8'h02, 8'h06, "w1c_status");

        // Set wins over same-cycle clear
        @(negedge clk);
        io_sel = 1; io_wr = 1; addr = 8'h02; wdata = 8'h10; in_valid = 1; in_data = 8'h03;
        $display("WR  addr=02 data=10 with IN 03");
        @(posedge clk); #1;
        io_sel = 0; io_wr = 0; in_valid = 0;
        rd_io(8'h02, 8'h16, "set_wins");
        rd_io(8'h01, 8'h01, "set_wins_hold");
        wr_io(8'h02, 8'h38);
        rd_io(8'h02, 8'h02, "final_clear");

        // Write and read together: write only
        @(negedge clk);
        io_sel = 1; io_wr = 1; io_rd = 1; addr = 8'h02; wdata = 8'h00;
        #2;
        check("wr_rd_no_oe", rdata_oe, 0);
        @(posedge clk); #1;
        io_sel = 0; io_wr = 0; io_rd = 0;

        // Reset mid-operation
        wr_io(8'h00, 8'hC1); wr_io(8'h00, 8'hC2);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        out_q.delete();
        check("midrst_valid", out_valid, 0);
        rd_io(8'h02, 8'h02, "midrst_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
